filter_ctrl: RTL and testbench
==============================

FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 Parameter SIZE_ADC_DATA, default 14, width of ADC samples, filter output and peak result.
REQ-002 Parameter SIZE_CFG, default 16, width of configuration write data and of filt_m1/filt_m2.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_we  in  1  configuration write strobe, one-cycle.
REQ-006 cfg_addr  in  2  register select: 0 = {l[15:8],k[7:0]}, 1 = m1, 2 = m2, 3 = threshold.
REQ-007 cfg_wdata  in  SIZE_CFG  write data.
REQ-008 adc_data  in  SIZE_ADC_DATA  raw sample, unsigned.
REQ-009 adc_valid  in  1  adc_data qualifier.
REQ-010 filt_data  in  SIZE_ADC_DATA  shaping-filter output, unsigned.
REQ-011 filt_clear  out  1  drives the filter reset input.
REQ-012 filt_k, filt_l  out  8 each  active filter delays.
REQ-013 filt_m1, filt_m2  out  SIZE_CFG each  active filter multipliers.
REQ-014 peak_data  out  SIZE_ADC_DATA  captured pulse maximum.
REQ-015 peak_valid  out  1  peak_data qualifier.
REQ-016 peak_ready  in  1  consumer accepts peak_data.
REQ-017 missed_cnt  out  8  triggers dropped while busy.
REQ-018 state  out  2  FSM state: 0 FLUSH, 1 ARMED, 2 CAPTURE, 3 HOLD.

Function
REQ-019 Config registers SHALL update on the cycle after cfg_we; k or l written as 0 SHALL be stored as 1.
REQ-020 filt_k/filt_l/filt_m1/filt_m2 SHALL be driven directly from the config registers.
REQ-021 Any accepted cfg_we, in any state, SHALL force the FSM to FLUSH next cycle, load the flush counter with k+l+4 (9-bit, using the new values) and drop any pending peak (peak_valid -> 0).
REQ-022 FLUSH: filt_clear = 1; counter decrements every cycle regardless of adc_valid; at count 0, go to ARMED with filt_clear = 0 from that cycle.
REQ-023 ARMED: when adc_valid = 1 and adc_data > threshold (strict), go to CAPTURE, load window counter with k+l+2, and clear the running maximum to 0.
REQ-024 CAPTURE: each cycle, running max <= max(running max, filt_data); window counter decrements; on the cycle it reaches 0 (final sample included), go to HOLD.
REQ-025 HOLD: peak_valid = 1 and peak_data = final running max, both stable until handshake.
REQ-026 Handshake: transfer occurs on a cycle with peak_valid = 1 and peak_ready = 1; FSM returns to ARMED next cycle with peak_valid = 0; peak_ready outside HOLD is ignored.
REQ-027 A qualifying trigger (REQ-023 condition) in CAPTURE or HOLD SHALL increment missed_cnt, saturating at 255; triggers in FLUSH SHALL NOT count.
REQ-028 missed_cnt SHALL clear only on reset or on a write to cfg_addr 3.
REQ-029 cfg_we coincident with a handshake: cfg_we wins (FLUSH); the peak counts as transferred.
REQ-030 Comparisons and max SHALL be unsigned, full SIZE_ADC_DATA width, no truncation.

Reset
REQ-031 On reset: k = 4, l = 8, m1 = 1, m2 = 1, threshold = all-ones (SIZE_ADC_DATA bits, zero-extended), missed_cnt = 0, peak_data = 0, peak_valid = 0.
REQ-032 On reset: FSM enters FLUSH with counter = 16, filt_clear = 1 during and after reset until the count expires.
REQ-033 Reset mid-CAPTURE or mid-HOLD SHALL discard the capture without asserting peak_valid.

Verification
REQ-034 Release reset, no writes -> filt_clear high 16 cycles after reset drops, state = 1, no trigger since threshold = 16383.
REQ-035 Write addr3 = 100, adc_data 101 with valid -> CAPTURE for 14 cycles; filt_data ramp 0..13 then 50 on last cycle -> peak_data = 50, peak_valid held until peak_ready.
REQ-036 Hold peak_ready = 0, apply 300 triggers -> missed_cnt saturates at 255; write addr3 -> missed_cnt = 0.
REQ-037 Write addr0 = 0x0000 in ARMED -> k = l = 1, filt_clear high 6 cycles, then ARMED.
REQ-038 cfg_we on same cycle as peak_valid & peak_ready -> FLUSH next cycle, peak_valid = 0, no second transfer.
REQ-039 adc_data = threshold exactly -> no trigger; reset asserted mid-CAPTURE -> state = 0, peak_valid never asserts.

Source files
------------

// File: rtl/filter_ctrl.sv
// Sequencer around an external shaping filter: flush after (re)configuration,
// arm on an ADC threshold crossing, capture the filter maximum over k+l+2 cycles, hold it for a handshake.
module filter_ctrl #(
  parameter int SIZE_ADC_DATA = 14,
  parameter int SIZE_CFG      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_addr,
  input  logic [SIZE_CFG-1:0]      cfg_wdata,
  input  logic [SIZE_ADC_DATA-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic [SIZE_ADC_DATA-1:0] filt_data,
  output logic                     filt_clear,
  output logic [7:0]               filt_k,
  output logic [7:0]               filt_l,
  output logic [SIZE_CFG-1:0]      filt_m1,
  output logic [SIZE_CFG-1:0]      filt_m2,
  output logic [SIZE_ADC_DATA-1:0] peak_data,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic [7:0]               missed_cnt,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_FLUSH   = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int CMP_W = (SIZE_CFG > SIZE_ADC_DATA) ? SIZE_CFG : SIZE_ADC_DATA;

  state_t                     state_q, state_d;
  logic [8:0]                 cnt_q, cnt_d;
  logic [7:0]                 k_q, k_d;
  logic [7:0]                 l_q, l_d;
  logic [SIZE_CFG-1:0]        m1_q, m1_d;
  logic [SIZE_CFG-1:0]        m2_q, m2_d;
  logic [SIZE_CFG-1:0]        thr_q, thr_d;
  logic [SIZE_ADC_DATA-1:0]   max_q, max_d;
  logic [7:0]                 missed_q, missed_d;
  logic                       trigger;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FLUSH;
      cnt_q    <= 9'd16;
      k_q      <= 8'd4;
      l_q      <= 8'd8;
      m1_q     <= SIZE_CFG'(1);
      m2_q     <= SIZE_CFG'(1);
      thr_q    <= SIZE_CFG'({SIZE_ADC_DATA{1'b1}});
      max_q    <= '0;
      missed_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      l_q      <= l_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      thr_q    <= thr_d;
      max_q    <= max_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    l_d      = l_q;
    m1_d     = m1_q;
    m2_d     = m2_q;
    thr_d    = thr_q;
    max_d    = max_q;
    missed_d = missed_q;

    // Both operands widened so a threshold above the ADC range can never trigger.
    trigger = adc_valid && (CMP_W'(adc_data) > CMP_W'(thr_q));

    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          k_d = (cfg_wdata[7:0]  == 8'd0) ? 8'd1 : cfg_wdata[7:0];
          l_d = (cfg_wdata[15:8] == 8'd0) ? 8'd1 : cfg_wdata[15:8];
        end
        2'd1:    m1_d  = cfg_wdata;
        2'd2:    m2_d  = cfg_wdata;
        default: thr_d = cfg_wdata;
      endcase
    end

    case (state_q)
      ST_FLUSH: begin
        if (cnt_q != 9'd0) cnt_d = cnt_q - 9'd1;
        if (cnt_q <= 9'd1) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trigger) begin
          state_d = ST_CAPTURE;
          cnt_d   = {1'b0, k_q} + {1'b0, l_q} + 9'd2;
          max_d   = '0;
        end
      end
      ST_CAPTURE: begin
        max_d = (filt_data > max_q) ? filt_data : max_q;
        if (cnt_q != 9'd0) cnt_d = cnt_q - 9'd1;
        if (cnt_q <= 9'd1) state_d = ST_HOLD;
        if (trigger && missed_q != 8'hFF) missed_d = missed_q + 8'd1;
      end
      ST_HOLD: begin
        if (peak_ready) state_d = ST_ARMED;
        if (trigger && missed_q != 8'hFF) missed_d = missed_q + 8'd1;
      end
    endcase

    // A configuration write overrides any transition, including a coincident handshake.
    if (cfg_we) begin
      state_d = ST_FLUSH;
      cnt_d   = {1'b0, k_d} + {1'b0, l_d} + 9'd4;
      if (cfg_addr == 2'd3) missed_d = 8'd0;
    end
  end

  assign filt_clear = (state_q == ST_FLUSH);
  assign peak_valid = (state_q == ST_HOLD);
  assign peak_data  = max_q;
  assign filt_k     = k_q;
  assign filt_l     = l_q;
  assign filt_m1    = m1_q;
  assign filt_m2    = m2_q;
  assign missed_cnt = missed_q;
  assign state      = state_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Bench for filter_ctrl: trigger table, directed corner sequences, then random traffic against a queue-based model.
module tb_filter_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [13:0] adc_data = 14'd0;
  logic        adc_valid = 1'b0;
  logic [13:0] filt_data = 14'd0;
  logic        peak_ready = 1'b0;
  logic        filt_clear, peak_valid;
  logic [7:0]  filt_k, filt_l, missed_cnt;
  logic [15:0] filt_m1, filt_m2;
  logic [13:0] peak_data;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  filter_ctrl #(.SIZE_ADC_DATA(14), .SIZE_CFG(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .adc_data(adc_data), .adc_valid(adc_valid), .filt_data(filt_data),
    .filt_clear(filt_clear), .filt_k(filt_k), .filt_l(filt_l), .filt_m1(filt_m1), .filt_m2(filt_m2),
    .peak_data(peak_data), .peak_valid(peak_valid), .peak_ready(peak_ready),
    .missed_cnt(missed_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim);
    int n = 0;
    while (state !== s && n < lim) begin
      step();
      n++;
    end
    chk("wait_state", 32'(state), 32'(s));
  endtask

  // ---------------- reference model ----------------
  int m_flush, m_cap, m_hold, m_k, m_l, m_m1, m_m2, m_thr, m_missed;
  int m_samp[$];

  function automatic int m_state();
    if (m_flush > 0) return 0;
    if (m_cap > 0)   return 2;
    if (m_hold != 0) return 3;
    return 1;
  endfunction

  function automatic int m_peak();
    int mx = 0;
    foreach (m_samp[i]) if (m_samp[i] > mx) mx = m_samp[i];
    return mx;
  endfunction

  task automatic model_step(input bit rst, input bit we, input int addr, input int wd,
                            input bit av, input int adc, input int filt, input bit rdy);
    int cur;
    bit trig;
    if (rst) begin
      m_flush = 16; m_cap = 0; m_hold = 0; m_k = 4; m_l = 8;
      m_m1 = 1; m_m2 = 1; m_thr = 16383; m_missed = 0; m_samp.delete();
      return;
    end
    cur  = m_state();
    trig = av && (adc > m_thr);
    if (trig && (cur == 2 || cur == 3) && m_missed < 255) m_missed++;
    if (we) begin
      case (addr)
        0: begin
          m_k = (wd % 256 == 0) ? 1 : wd % 256;
          m_l = (wd / 256 == 0) ? 1 : wd / 256;
        end
        1: m_m1 = wd;
        2: m_m2 = wd;
        default: begin m_thr = wd; m_missed = 0; end
      endcase
      m_flush = m_k + m_l + 4; m_cap = 0; m_hold = 0;
      return;
    end
    case (cur)
      0: m_flush--;
      1: if (trig) begin m_cap = m_k + m_l + 2; m_samp.delete(); end
      2: begin
        m_samp.push_back(filt);
        m_cap--;
        if (m_cap == 0) m_hold = 1;
      end
      default: if (rdy) m_hold = 0;
    endcase
  endtask

  task automatic check_model();
    chk("rnd_state", 32'(state), 32'(m_state()));
    chk("rnd_clear", 32'(filt_clear), 32'(m_state() == 0));
    chk("rnd_pvalid", 32'(peak_valid), 32'(m_state() == 3));
    chk("rnd_missed", 32'(missed_cnt), 32'(m_missed));
    chk("rnd_k", 32'(filt_k), 32'(m_k));
    chk("rnd_l", 32'(filt_l), 32'(m_l));
    chk("rnd_m1", 32'(filt_m1), 32'(m_m1));
    chk("rnd_m2", 32'(filt_m2), 32'(m_m2));
    if (m_state() == 3) chk("rnd_peak", 32'(peak_data), 32'(m_peak()));
  endtask

  // ---------------- trigger table ----------------
  typedef struct {
    logic [15:0] thr;
    logic [13:0] adc;
    logic        vld;
    logic [1:0]  exp_state;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int n, pv_seen;
    bit r_rst, r_we, r_av, r_rdy;
    int r_addr, r_wd, r_adc, r_filt;

    vecs[0] = '{16'd100,   14'd101,   1'b1, 2'd2};
    vecs[1] = '{16'd100,   14'd100,   1'b1, 2'd1};
    vecs[2] = '{16'd100,   14'd101,   1'b0, 2'd1};
    vecs[3] = '{16'd0,     14'd1,     1'b1, 2'd2};
    vecs[4] = '{16'd0,     14'd0,     1'b1, 2'd1};
    vecs[5] = '{16'd16383, 14'd16383, 1'b1, 2'd1};
    vecs[6] = '{16'd16382, 14'd16383, 1'b1, 2'd2};
    vecs[7] = '{16'd16384, 14'd16383, 1'b1, 2'd1};
    vecs[8] = '{16'hFFFF,  14'd16383, 1'b1, 2'd1};

    // Reset values and initial flush length.
    reset = 1'b1;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_clear", 32'(filt_clear), 1);
    chk("rst_k", 32'(filt_k), 4);
    chk("rst_l", 32'(filt_l), 8);
    chk("rst_m1", 32'(filt_m1), 1);
    chk("rst_m2", 32'(filt_m2), 1);
    chk("rst_missed", 32'(missed_cnt), 0);
    chk("rst_pvalid", 32'(peak_valid), 0);
    chk("rst_pdata", 32'(peak_data), 0);
    reset = 1'b0;
    n = 0;
    while (filt_clear && n < 100) begin n++; step(); end
    chk("rst_flush_len", 32'(n), 16);
    chk("rst_armed", 32'(state), 1);
    adc_data = 14'd16383; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    chk("default_thr_no_trig", 32'(state), 1);

    foreach (vecs[i]) begin
      cfg_write(2'd3, vecs[i].thr);
      wait_state(2'd1, 100);
      adc_data = vecs[i].adc; adc_valid = vecs[i].vld;
      step();
      adc_valid = 1'b0;
      chk("trig_vec", 32'(state), 32'(vecs[i].exp_state));
    end

    // Capture of a ramp ending in the peak on the final window sample.
    cfg_write(2'd3, 16'd100);
    wait_state(2'd1, 100);
    adc_data = 14'd101; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    chk("cap_enter", 32'(state), 2);
    n = 0;
    while (state == 2'd2 && n < 100) begin
      filt_data = (n == 13) ? 14'd50 : 14'(n);
      n++;
      step();
    end
    chk("cap_len", 32'(n), 14);
    chk("hold_state", 32'(state), 3);
    chk("hold_pvalid", 32'(peak_valid), 1);
    chk("hold_pdata", 32'(peak_data), 50);
    filt_data = 14'h3FFF;
    for (int i = 0; i < 5; i++) step();
    chk("hold_stable_v", 32'(peak_valid), 1);
    chk("hold_stable_d", 32'(peak_data), 50);
    peak_ready = 1'b1;
    step();
    peak_ready = 1'b0;
    chk("hs_state", 32'(state), 1);
    chk("hs_pvalid", 32'(peak_valid), 0);

    // Missed-trigger counting and saturation.
    adc_data = 14'd101; adc_valid = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 9) chk("missed_partial", 32'(missed_cnt), 10);
    end
    adc_valid = 1'b0;
    chk("missed_sat", 32'(missed_cnt), 255);
    chk("missed_hold", 32'(state), 3);
    cfg_write(2'd3, 16'd100);
    chk("missed_clr", 32'(missed_cnt), 0);
    chk("cfg_drop_pvalid", 32'(peak_valid), 0);
    chk("cfg_flush", 32'(state), 0);
    adc_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    adc_valid = 1'b0;
    chk("flush_no_count", 32'(missed_cnt), 0);
    wait_state(2'd1, 100);

    // k/l written as zero become one; flush shortens to six cycles.
    cfg_write(2'd0, 16'h0000);
    chk("kl0_k", 32'(filt_k), 1);
    chk("kl0_l", 32'(filt_l), 1);
    n = 0;
    while (filt_clear && n < 100) begin n++; step(); end
    chk("kl0_flush_len", 32'(n), 6);
    chk("kl0_armed", 32'(state), 1);

    // Configuration write coincident with a handshake.
    adc_data = 14'd101; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    wait_state(2'd3, 20);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd7; peak_ready = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("cfghs_state", 32'(state), 0);
    chk("cfghs_pvalid", 32'(peak_valid), 0);
    chk("cfghs_m1", 32'(filt_m1), 7);
    chk("cfghs_m2", 32'(filt_m2), 1);
    pv_seen = 0;
    n = 0;
    while (state != 2'd1 && n < 50) begin
      if (peak_valid) pv_seen++;
      n++;
      step();
    end
    peak_ready = 1'b0;
    chk("cfghs_no_second", 32'(pv_seen), 0);
    chk("cfghs_armed", 32'(state), 1);

    // Reset in the middle of a capture.
    adc_data = 14'd101; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    step();
    chk("midcap_state", 32'(state), 2);
    reset = 1'b1;
    step();
    chk("midcap_rst_state", 32'(state), 0);
    chk("midcap_rst_pvalid", 32'(peak_valid), 0);
    reset = 1'b0;
    pv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (peak_valid) pv_seen++;
      step();
    end
    chk("midcap_no_peak", 32'(pv_seen), 0);
    chk("midcap_armed", 32'(state), 1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) check_model();
      r_rst  = (c == 0) || ($urandom_range(0, 399) == 0);
      r_we   = !r_rst && ($urandom_range(0, 39) == 0);
      r_addr = int'($urandom_range(0, 3));
      case (r_addr)
        0:       r_wd = int'($urandom_range(0, 5) * 256 + $urandom_range(0, 5));
        3:       r_wd = int'($urandom_range(6000, 17000));
        default: r_wd = int'($urandom_range(0, 65535));
      endcase
      r_av   = ($urandom_range(0, 1) == 1);
      r_adc  = int'($urandom_range(0, 16383));
      r_filt = int'($urandom_range(0, 16383));
      r_rdy  = ($urandom_range(0, 2) == 0);
      reset = r_rst; cfg_we = r_we; cfg_addr = 2'(r_addr); cfg_wdata = 16'(r_wd);
      adc_valid = r_av; adc_data = 14'(r_adc); filt_data = 14'(r_filt); peak_ready = r_rdy;
      model_step(r_rst, r_we, r_addr, r_wd, r_av, r_adc, r_filt, r_rdy);
      step();
    end
    check_model();
    reset = 1'b0; cfg_we = 1'b0; adc_valid = 1'b0; peak_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
